cbus_read_mux: RTL and testbench
================================

Name: cbus_read_mux

Overview:
- Parametrised read-data return path for the control bus (CBus). It replaces the fixed two-slave merge with NUM_SLV slaves and per-slave base decode.
- Adds a req/ack handshake so slaves may return data with variable latency. A timeout counter returns an error word when a slave never acknowledges.
- Sits between the CBus master (PS-side bridge) and the register slaves (axi2s, ad9361, and later additions).

Parameters:
- NUM_SLV, 4, number of slave channels (1..16).
- DW, 32, data width.
- AW, 18, CBus address width.
- PAGE_BITS, 8, low address bits inside a slave page. Decode compares addr[AW-1:PAGE_BITS].
- SLV_BASE, {NUM_SLV{18'h0}}, flat NUM_SLV*AW vector. Slice k is the base of slave k; its low PAGE_BITS bits are ignored.
- TIMEOUT, 16, maximum number of WAIT cycles before an error response (>=1).
- ERR_DATA, 32'hDEADBEEF, data returned on timeout.

Ports:
- clk  in  1  bus clock.
- rst  in  1  synchronous reset, active-low.
- en  in  1  read strobe, one cycle per read.
- addr  in  AW  read address, sampled when en is accepted.
- rd_req  out  NUM_SLV  one-hot read request, one-cycle pulse to the selected slave.
- slv_dout  in  NUM_SLV*DW  slave read data, slice k belongs to slave k.
- slv_ack  in  NUM_SLV  slave data-valid, slice k belongs to slave k.
- dout  out  DW  read data, registered, held between reads.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- err  out  1  one-cycle pulse, coincident with dout_valid, on timeout.
- busy  out  1  high while a read is outstanding.
- ovf  out  1  sticky flag: an en arrived while busy. Cleared only by reset.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - dout=0, dout_valid=0, err=0, rd_req=0, busy=0, ovf=0, timer=0.
  - An ack arriving after a mid-WAIT reset is ignored.
- Decode:
  - Slave k hits when addr[AW-1:PAGE_BITS] == SLV_BASE[k*AW+AW-1 : k*AW+PAGE_BITS].
  - If several slaves match, the lowest index wins. No match is a miss.
- State machine with states IDLE and WAIT; busy = (state==WAIT).
- IDLE, en=1, hit on slave k:
  - Latch sel=k.
  - rd_req[k]=1 on the next cycle only.
  - Go to WAIT with timer=0.
- IDLE, en=1, miss:
  - Next cycle dout=0 and dout_valid=1 (legacy default-0 behaviour), err=0.
  - Stay in IDLE.
- WAIT, each cycle:
  - If slv_ack[sel]=1: dout=slv_dout[sel], dout_valid=1, go to IDLE.
  - Else if timer==TIMEOUT-1: dout=ERR_DATA, dout_valid=1, err=1, go to IDLE.
  - Else timer+1.
  - slv_ack on non-selected channels is ignored.
  - An ack coincident with the last timeout cycle wins; no error is raised.
- The ack is sampled from the first WAIT cycle, i.e. the cycle rd_req is high. Zero-wait slaves may ack combinationally.
- Latency, with en sampled at edge t:
  - miss: dout_valid at t+1.
  - hit with ack in the rd_req cycle: dout_valid at t+2.
  - timeout: dout_valid and err at t+TIMEOUT+1.
- Throughput: en is accepted in the same cycle that dout_valid pulses, because state is already IDLE. This gives back-to-back reads.
- en while in WAIT: the request is dropped, ovf is set to 1, and the outstanding read is unaffected.
- Registers:
  - dout holds its last value when dout_valid=0.
  - addr is captured only on acceptance; later changes to addr have no effect.
- The timer is sized $clog2(TIMEOUT+1) bits and does not wrap beyond TIMEOUT-1.

Decomposition:
- Package cbus_pkg:
  - CBUS_AW=18, CBUS_DW=32, CBUS_PAGE_BITS=8.
  - Base constants AXI2SREG_BASE and AD9361REG_BASE.
  - CBUS_ERR_DATA.
  - State encoding IDLE/WAIT.
- Sub-module cbus_addr_decode:
  - Parameters NUM_SLV, AW, PAGE_BITS, SLV_BASE.
  - Input addr; outputs hit and sel (index, $clog2(NUM_SLV) bits) with priority encode.
  - Purely combinational; reused by the write path.

Test Plan:
- Reset sequencing: hold rst=0 for 3 cycles with en=1 and acks toggling -> all outputs 0 and ovf=0 throughout.
- Hit, zero-wait: SLV_BASE[1]=18'h00100, en with addr=18'h00124, slave 1 acks in the rd_req cycle with 32'h12345678:
  - rd_req=4'b0010 for exactly 1 cycle.
  - dout=32'h12345678 and dout_valid at t+2; err=0.
- Miss: addr=18'h3FF00 with no base matching -> dout=0, dout_valid at t+1, rd_req never asserted.
- Timeout: TIMEOUT=16, slave 2 never acks, other slaves ack every cycle:
  - dout=32'hDEADBEEF with err=1 at t+17.
  - busy high t+1..t+16.
  - Repeat with the ack arriving on the 16th WAIT cycle -> slave data returned, err=0.
- Overlap and back-to-back:
  - en again during WAIT -> ovf=1 (sticky), first read completes normally.
  - en in the dout_valid cycle -> second read accepted.
- Reset mid-WAIT: assert rst=0 in the 3rd WAIT cycle, then a late ack -> state IDLE, no dout_valid, dout=0.

Source files
------------

// File: rtl/cbus_pkg.sv
// Shared CBus constants, slave base addresses and read-path state encoding.
package cbus_pkg;

   localparam int unsigned CBUS_AW        = 18;
   localparam int unsigned CBUS_DW        = 32;
   localparam int unsigned CBUS_PAGE_BITS = 8;

   // Register page bases of the existing slaves
   localparam logic [CBUS_AW-1:0] AXI2SREG_BASE  = 18'h00000;
   localparam logic [CBUS_AW-1:0] AD9361REG_BASE = 18'h00100;

   // Word returned when a selected slave never acknowledges
   localparam logic [CBUS_DW-1:0] CBUS_ERR_DATA = 32'hDEADBEEF;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } cbus_state_e;

   // Width of a slave index; a single slave still needs one bit to carry it
   function automatic int unsigned cbus_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cbus_addr_decode.sv
// Page decode of a CBus address against per-slave bases; lowest index wins.
// Purely combinational so the write path can share it.
module cbus_addr_decode
   import cbus_pkg::*;
#(
   parameter int unsigned              NUM_SLV   = 4,
   parameter int unsigned              AW        = CBUS_AW,
   parameter int unsigned              PAGE_BITS = CBUS_PAGE_BITS,
   parameter logic [NUM_SLV*AW-1:0]    SLV_BASE  = '0,
   localparam int unsigned             SW        = cbus_idx_w(NUM_SLV)
) (
   input  logic [AW-1:0] addr,
   output logic          hit,
   output logic [SW-1:0] sel
);

   localparam int unsigned PW = AW - PAGE_BITS;

   logic [PW-1:0] page;

   assign page = addr[AW-1:PAGE_BITS];

   // Offset bits inside a page take no part in slave selection
   generate
      if (PAGE_BITS > 0) begin : g_offset
         logic unused_offset;
         assign unused_offset = ^addr[PAGE_BITS-1:0];
      end
   endgenerate

   // Priority encode: first matching base from index 0 upward
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int unsigned k = 0; k < NUM_SLV; k++) begin
         if (!hit && (page == SLV_BASE[k*AW+PAGE_BITS +: PW])) begin
            hit = 1'b1;
            sel = SW'(k);
         end
      end
   end

endmodule

// File: rtl/cbus_read_mux.sv
// CBus read-data return path: decodes the read address to one of NUM_SLV
// slaves, pulses its rd_req, waits for its ack (or times out) and returns a
// registered data word with a one-cycle valid strobe.
module cbus_read_mux
   import cbus_pkg::*;
#(
   parameter int unsigned           NUM_SLV   = 4,
   parameter int unsigned           DW        = CBUS_DW,
   parameter int unsigned           AW        = CBUS_AW,
   parameter int unsigned           PAGE_BITS = CBUS_PAGE_BITS,
   parameter logic [NUM_SLV*AW-1:0] SLV_BASE  = '0,
   parameter int unsigned           TIMEOUT   = 16,
   parameter logic [DW-1:0]         ERR_DATA  = CBUS_ERR_DATA
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [AW-1:0]         addr,
   output logic [NUM_SLV-1:0]    rd_req,
   input  logic [NUM_SLV*DW-1:0] slv_dout,
   input  logic [NUM_SLV-1:0]    slv_ack,
   output logic [DW-1:0]         dout,
   output logic                  dout_valid,
   output logic                  err,
   output logic                  busy,
   output logic                  ovf
);

   localparam int unsigned   SW         = cbus_idx_w(NUM_SLV);
   localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   logic               dec_hit;
   logic [SW-1:0]      dec_sel;

   cbus_state_e        state_q;
   logic [SW-1:0]      sel_q;
   logic [TW-1:0]      timer_q;
   logic [NUM_SLV-1:0] rd_req_q;
   logic [NUM_SLV-1:0] rd_req_d;
   logic [DW-1:0]      dout_q;
   logic               dout_valid_q;
   logic               err_q;
   logic               ovf_q;

   logic               ack_sel;
   logic [DW-1:0]      data_sel;

   cbus_addr_decode #(
      .NUM_SLV   (NUM_SLV),
      .AW        (AW),
      .PAGE_BITS (PAGE_BITS),
      .SLV_BASE  (SLV_BASE)
   ) u_decode (
      .addr (addr),
      .hit  (dec_hit),
      .sel  (dec_sel)
   );

   // One-hot request vector for the slave picked by the decoder
   always_comb begin
      rd_req_d = '0;
      for (int unsigned k = 0; k < NUM_SLV; k++) begin
         if (SW'(k) == dec_sel) begin
            rd_req_d[k] = 1'b1;
         end
      end
   end

   // Ack and data of the latched slave; other channels are never looked at
   always_comb begin
      ack_sel  = 1'b0;
      data_sel = '0;
      for (int unsigned k = 0; k < NUM_SLV; k++) begin
         if (SW'(k) == sel_q) begin
            ack_sel  = slv_ack[k];
            data_sel = slv_dout[k*DW +: DW];
         end
      end
   end

   // Read sequencing: accept and decode in IDLE, wait for ack or timeout in WAIT
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         timer_q      <= '0;
         rd_req_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         err_q        <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         rd_req_q     <= '0;
         dout_valid_q <= 1'b0;
         err_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  if (dec_hit) begin
                     sel_q    <= dec_sel;
                     rd_req_q <= rd_req_d;
                     timer_q  <= '0;
                     state_q  <= WAIT;
                  end else begin
                     // Unmapped address reads back as zero without waiting
                     dout_q       <= '0;
                     dout_valid_q <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (en) begin
                  ovf_q <= 1'b1;
               end
               // Ack is checked before the timer so a last-cycle ack still wins
               if (ack_sel) begin
                  dout_q       <= data_sel;
                  dout_valid_q <= 1'b1;
                  timer_q      <= '0;
                  state_q      <= IDLE;
               end else if (timer_q == TIMER_LAST) begin
                  dout_q       <= ERR_DATA;
                  dout_valid_q <= 1'b1;
                  err_q        <= 1'b1;
                  timer_q      <= '0;
                  state_q      <= IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rd_req     = rd_req_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign err        = err_q;
   assign busy       = (state_q == WAIT);
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_cbus_read_mux.sv
// Scoreboard bench for cbus_read_mux: stimulus pushes the expected response
// (data, err, arrival cycle); a negedge monitor compares every cycle.
module tb_cbus_read_mux;

   localparam int unsigned NS   = 4;
   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 18;
   localparam int unsigned PB   = 8;
   localparam int unsigned TO   = 16;
   localparam logic [31:0] ERRW = 32'hDEADBEEF;
   // slave0 page 0x000, slave1 page 0x001, slave2 page 0x002, slave3 duplicates slave1
   localparam logic [NS*AW-1:0] BASES = {18'h00100, 18'h00200, 18'h00100, 18'h00000};

   logic             clk  = 1'b0;
   logic             rst  = 1'b0;
   logic             en   = 1'b0;
   logic [AW-1:0]    addr = '0;
   logic [NS-1:0]    rd_req;
   logic [NS*DW-1:0] slv_dout;
   logic [NS-1:0]    slv_ack;
   logic [DW-1:0]    dout;
   logic             dout_valid;
   logic             err;
   logic             busy;
   logic             ovf;

   always #5 clk = ~clk;

   cbus_read_mux #(
      .NUM_SLV   (NS),
      .DW        (DW),
      .AW        (AW),
      .PAGE_BITS (PB),
      .SLV_BASE  (BASES),
      .TIMEOUT   (TO),
      .ERR_DATA  (ERRW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .addr       (addr),
      .rd_req     (rd_req),
      .slv_dout   (slv_dout),
      .slv_ack    (slv_ack),
      .dout       (dout),
      .dout_valid (dout_valid),
      .err        (err),
      .busy       (busy),
      .ovf        (ovf)
   );

   // cycle counter: cyc==t is the cycle after the edge that sampled en
   int unsigned cyc   = 0;
   logic        rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // slave model: channel ack_ch acks once at ack_cyc, others follow noise_en
   int unsigned ack_ch   = NS;
   int unsigned ack_cyc  = 32'hFFFF_FFFF;
   logic [31:0] ack_data = '0;
   logic        noise_en = 1'b0;
   always_comb begin
      for (int unsigned k = 0; k < NS; k++) begin
         if (k == ack_ch) begin
            slv_ack[k]            = (cyc == ack_cyc);
            slv_dout[k*DW +: DW]  = ack_data;
         end else begin
            slv_ack[k]            = noise_en;
            slv_dout[k*DW +: DW]  = 32'hBAD0_0000 | k;
         end
      end
   end

   typedef struct {
      logic [31:0] d;
      logic        e;
      int unsigned c;
   } exp_t;

   exp_t          sb[$];
   int unsigned   checks    = 0;
   int unsigned   errors    = 0;
   logic [31:0]   last_dout = '0;
   int unsigned   req_t     = 32'hFFFF_FFFF;
   logic [NS-1:0] req_mask  = '0;
   int unsigned   busy_from = 1;
   int unsigned   busy_to   = 0;
   logic          ovf_on    = 1'b0;
   int unsigned   ovf_cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // reference decode on page numbers: first slave whose page equals addr's page
   function automatic int ref_decode(input logic [AW-1:0] a);
      logic [AW-1:0] b;
      for (int k = 0; k < int'(NS); k++) begin
         b = BASES[k*AW +: AW];
         if ((a >> PB) == (b >> PB)) return k;
      end
      return -1;
   endfunction

   // monitor
   always @(negedge clk) begin
      exp_t e;
      logic exp_v;
      if (!rst_q) begin
         chk("reset_dout", dout, 32'h0);
         chk("reset_flags", {24'h0, rd_req, dout_valid, err, busy, ovf}, 32'h0);
      end else begin
         exp_v = (sb.size() != 0) && (sb[0].c == cyc);
         chk("dout_valid", 32'(dout_valid), 32'(exp_v));
         chk("rd_req", 32'(rd_req), (cyc == req_t) ? 32'(req_mask) : 32'h0);
         chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc <= busy_to)));
         chk("ovf", 32'(ovf), 32'(ovf_on && (cyc >= ovf_cyc)));
         if (exp_v) begin
            e = sb.pop_front();
            if (dout_valid) begin
               chk("dout", dout, e.d);
               chk("err", 32'(err), 32'(e.e));
            end
            last_dout = e.d;
         end else begin
            chk("dout_hold", dout, last_dout);
            chk("err_idle", 32'(err), 32'h0);
         end
      end
   end

   // issue one accepted read from IDLE; returns at the next negedge (cyc==t)
   task automatic issue(input logic [AW-1:0] a, input int unsigned d,
                        input logic [31:0] data, output int unsigned vc);
      int          ch;
      int unsigned t;
      exp_t        e;
      t  = cyc + 1;
      ch = ref_decode(a);
      en   = 1'b1;
      addr = a;
      if (ch < 0) begin
         vc  = t;
         e.d = 32'h0;
         e.e = 1'b0;
      end else begin
         vc       = t + ((d < TO) ? d : TO - 1) + 1;
         ack_ch   = unsigned'(ch);
         ack_data = data;
         ack_cyc  = (d < TO) ? t + d : 32'hFFFF_FFFF;
         req_t    = t;
         req_mask = NS'(1) << ch;
         busy_from = t;
         busy_to   = vc - 1;
         e.d = (d < TO) ? data : ERRW;
         e.e = (d >= TO);
      end
      e.c = vc;
      sb.push_back(e);
      @(negedge clk);
      en   = 1'b0;
      addr = AW'($urandom);
   endtask

   // strobe en while a read is outstanding
   task automatic overlap(input logic [AW-1:0] a);
      en   = 1'b1;
      addr = a;
      if (!ovf_on) begin
         ovf_on  = 1'b1;
         ovf_cyc = cyc + 1;
      end
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset(input int unsigned n);
      rst = 1'b0;
      @(negedge clk);
      sb.delete();
      req_t     = 32'hFFFF_FFFF;
      busy_from = 1;
      busy_to   = 0;
      ovf_on    = 1'b0;
      last_dout = '0;
      repeat (n - 1) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin
      int unsigned   vc, vc2, t;
      logic [AW-1:0] a;
      logic [9:0]    page;
      int unsigned   d;

      // reset held with en high and acks toggling
      en = 1'b1;
      addr = 18'h00124;
      repeat (3) begin
         noise_en = ~noise_en;
         @(negedge clk);
      end
      rst = 1'b1;
      en = 1'b0;
      noise_en = 1'b0;
      repeat (2) @(negedge clk);

      // zero-wait hit on slave 1 (slave 3 shares the page but loses priority)
      issue(18'h00124, 0, 32'h12345678, vc);
      wait_until(vc + 2);

      // miss
      issue(18'h3FF00, 0, 32'h0, vc);
      wait_until(vc + 2);

      // timeout on slave 2 with every other slave acking
      noise_en = 1'b1;
      issue(18'h00205, TO, 32'h0, vc);
      wait_until(vc + 1);
      // ack on the last WAIT cycle beats the timeout
      issue(18'h002A0, TO - 1, 32'hCAFE0016, vc);
      wait_until(vc + 1);
      noise_en = 1'b0;

      // en during WAIT: dropped, ovf sticky
      issue(18'h00010, 6, 32'hA5A5_0001, vc);
      wait_until(cyc + 2);
      overlap(18'h00200);
      wait_until(vc + 2);

      // back-to-back: next en in the dout_valid cycle
      issue(18'h00033, 2, 32'h0BB0_0001, vc);
      wait_until(vc);
      issue(18'h00277, 0, 32'h0BB0_0002, vc2);
      wait_until(vc2);
      issue(18'h3FF00, 0, 32'h0, vc);
      wait_until(vc);
      issue(18'h001FF, 4, 32'h0BB0_0003, vc);
      wait_until(vc + 2);

      // reset in the 3rd WAIT cycle, ack arrives later and must be ignored
      issue(18'h00200, 10, 32'h1A7E_0000, vc);
      t = cyc;
      wait_until(t + 2);
      do_reset(2);
      wait_until(t + 14);

      // randomized reads
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       page = 10'h000;
            1:       page = 10'h001;
            2:       page = 10'h002;
            default: page = 10'($urandom);
         endcase
         a = {page, 8'($urandom)};
         d = $urandom_range(0, TO + 2);
         noise_en = 1'($urandom);
         issue(a, d, $urandom, vc);
         if ((cyc >= busy_from) && (cyc <= busy_to) && ($urandom_range(0, 2) == 0)) begin
            wait_until($urandom_range(cyc, busy_to));
            overlap(AW'($urandom));
         end
         wait_until(vc);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
